multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore/Mealy FSM that sequences the multi-cycle MIPS datapath: shared memory, IR, ALU, PC, regfile.
//  Decodes opcode in DECODE, then steps through per-class states. Supported: R-type, lw, sw, beq, bne, j, addi, andi.
//  Stalls on a memory ready handshake. Traps illegal opcodes.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states hold until memReady=1; 0: memReady ignored, every state lasts 1 cycle
//  STATE_W        4  width of the state debug output
// PORTS
//  clk          in   1  rising-edge clock
//  rstn         in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  memReady     in   1  memory completes the current access this cycle
//  halt         in   1  hold in IDLE; sampled only in IDLE
//  pcWr         out  1  unconditional PC write
//  pcWrBeq      out  1  PC write if ALU zero
//  pcWrBne      out  1  PC write if ALU !zero
//  iorD         out  1  memory address: 0=PC, 1=ALUOut
//  memRd        out  1  memory read strobe
//  memWr        out  1  memory write strobe
//  irWr         out  1  load IR from memory data
//  mem2Reg      out  1  regfile write data: 0=ALUOut, 1=MDR
//  regDst       out  1  dest reg: 0=rt, 1=rd
//  regWr        out  1  regfile write enable
//  ALUSrcA      out  1  ALU A input: 0=PC, 1=regA
//  ALUSrcB      out  2  ALU B input: 00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=use funct, 11=and
//  pcSrc        out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
//  instrDone    out  1  1-cycle pulse on the last cycle of each instruction
//  illegal      out  1  sticky; set on entering TRAP
//  state        out  STATE_W  current state encoding, for debug
// BEHAVIOUR
//  Reset: state=IDLE; illegal=0. IDLE outputs are all 0.
//  Any output not listed as asserted in a state is 0.
//  rstn low mid-instruction returns the FSM to IDLE at once, with no partial writes after the assert.
//  States and transitions:
//   IDLE     : halt ? IDLE : FETCH
//   FETCH    : memRd=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, pcSrc=00.
//              irWr and pcWr are asserted only while ready is high. ready = memReady | ~MEM_HANDSHAKE.
//              Stays in FETCH until ready, then goes to DECODE.
//   DECODE   : ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
//              Next state by opcode: 000000->EXEC; 100011/101011->MEMADDR; 000100/000101->BRANCH; 000010->JUMP;
//              001000/001100->IEXEC; any other opcode->TRAP.
//   MEMADDR  : ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw->MEMREAD, sw->MEMWRITE.
//   MEMREAD  : memRd=1, iorD=1. Stays until ready, then goes to MEMWB.
//   MEMWB    : regWr=1, regDst=0, mem2Reg=1, instrDone=1. Next: FETCH.
//   MEMWRITE : memWr=1, iorD=1. instrDone is asserted with ready. Stays until ready, then goes to FETCH.
//              memRd stays 0 in MEMWRITE.
//   EXEC     : ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
//   RWB      : regWr=1, regDst=1, mem2Reg=0, instrDone=1. Next: FETCH.
//   IEXEC    : ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi. Next: IWB.
//   IWB      : regWr=1, regDst=0, mem2Reg=0, instrDone=1. Next: FETCH.
//   BRANCH   : ALUSrcA=1, ALUSrcB=00, ALUOp=01, pcSrc=01, instrDone=1.
//              pcWrBeq=1 for beq; pcWrBne=1 for bne. Next: FETCH.
//   JUMP     : pcWr=1, pcSrc=10, instrDone=1. Next: FETCH.
//   TRAP     : illegal=1. All write strobes 0. Stays in TRAP until reset.
//  Latency with ready always high: R/addi/andi/sw=4 cycles, lw=5, beq/bne/j=3.
//  Each wait cycle adds 1 cycle.
//  While a state waits on memReady, its outputs are held stable, except the ready-qualified irWr, pcWr and instrDone.
//  The opcode is latched internally in DECODE and used for all later states.
//  The IR output may change after DECODE without affecting the sequence.
//  halt is ignored outside IDLE. IDLE is entered only from reset.
//  State register: binary encoding. Unused encodings go to TRAP.
// TESTING
//  1. Reset, halt=0, memReady=1, opcode=000000 -> states IDLE,FETCH,DECODE,EXEC,RWB,FETCH.
//     regWr=1 and regDst=1 only in RWB; one instrDone pulse.
//  2. lw (100011) with memReady low 2 cycles in FETCH and 3 in MEMREAD.
//     -> memRd held; irWr is a single pulse; mem2Reg=1 with regWr in MEMWB; total 10 cycles.
//  3. sw (101011), memReady=1 -> memWr=1 for exactly 1 cycle with iorD=1.
//     memRd=0 in MEMWRITE; regWr never 1; 4 cycles.
//  4. beq (000100), then bne (000101) -> in BRANCH, ALUOp=01, pcSrc=01.
//     Only pcWrBeq resp. only pcWrBne is asserted; 3 cycles each.
//  5. j (000010) -> JUMP asserts pcWr=1, pcSrc=10, regWr=0.
//     addi/andi -> IEXEC ALUOp=00/11, IWB regDst=0.
//  6. Opcode 111111 -> TRAP, illegal=1 sticky, no strobes.
//     Also: rstn pulsed low in MEMREAD -> IDLE with all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_control.sv
// Control sequencer for a multi-cycle MIPS datapath: fetch/decode, per-class execution
// states, memory-ready stalls and a sticky trap for unsupported opcodes.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    input  logic               halt,
    output logic               pcWr,
    output logic               pcWrBeq,
    output logic               pcWrBne,
    output logic               iorD,
    output logic               memRd,
    output logic               memWr,
    output logic               irWr,
    output logic               mem2Reg,
    output logic               regDst,
    output logic               regWr,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         pcSrc,
    output logic               instrDone,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_IEXEC    = 4'd9,
        S_IWB      = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_beq;
        logic       pc_wr_bne;
        logic       ior_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem2reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    state_e     state_q, state_d;
    logic [5:0] op_q;
    logic [5:0] op_eff;
    ctrl_t      ctrl_q;
    logic       illegal_q;
    logic       ready;
    logic       fetch_rdy;
    logic       write_rdy;

    assign ready = memReady | ~MEM_HANDSHAKE;

    // State-only part of the control word; the ready-qualified strobes are added at the ports.
    function automatic ctrl_t moore_decode(input state_e s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_rd    = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.mem_rd = 1'b1;
                c.ior_d  = 1'b1;
            end
            S_MEMWB: begin
                c.reg_wr     = 1'b1;
                c.mem2reg    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_wr = 1'b1;
                c.ior_d  = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_wr     = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_IWB: begin
                c.reg_wr     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_src     = 2'b01;
                c.instr_done = 1'b1;
                c.pc_wr_beq  = (op == OP_BEQ);
                c.pc_wr_bne  = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_wr      = 1'b1;
                c.pc_src     = 2'b10;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // In DECODE the IR is live; afterwards only the latched copy is trusted.
    assign op_eff = (state_q == S_DECODE) ? opcode : op_q;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!halt) state_d = S_FETCH;
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                if (op_q == OP_LW)      state_d = S_MEMREAD;
                else if (op_q == OP_SW) state_d = S_MEMWRITE;
                else                    state_d = S_TRAP;
            end
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_RWB;
            S_IEXEC:    state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Control word is registered from the next state so it lines up with state_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ctrl_q  <= moore_decode(state_d, op_eff);
            if (state_q == S_DECODE) op_q <= opcode;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    assign fetch_rdy = (state_q == S_FETCH) & ready;
    assign write_rdy = (state_q == S_MEMWRITE) & ready;

    assign pcWr      = ctrl_q.pc_wr | fetch_rdy;
    assign irWr      = fetch_rdy;
    assign instrDone = ctrl_q.instr_done | write_rdy;
    assign pcWrBeq   = ctrl_q.pc_wr_beq;
    assign pcWrBne   = ctrl_q.pc_wr_bne;
    assign iorD      = ctrl_q.ior_d;
    assign memRd     = ctrl_q.mem_rd;
    assign memWr     = ctrl_q.mem_wr;
    assign mem2Reg   = ctrl_q.mem2reg;
    assign regDst    = ctrl_q.reg_dst;
    assign regWr     = ctrl_q.reg_wr;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ALUOp     = ctrl_q.alu_op;
    assign pcSrc     = ctrl_q.pc_src;
    assign illegal   = illegal_q;
    assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table checked against a
// spec-level output model, plus asynchronous reset sequences.
module tb_multicycle_control;

    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADDR = 4'd3, MEMREAD = 4'd4,
        MEMWB = 4'd5, MEMWRITE = 4'd6, EXEC = 4'd7, RWB = 4'd8, IEXEC = 4'd9,
        IWB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12, TRAP = 4'd13
    } st_e;

    typedef struct {
        string      name;
        logic       halt;
        logic       mem_ready;
        logic [5:0] opcode;
        st_e        exp_state;
    } vec_t;

    logic       clk, rstn, memReady, halt;
    logic [5:0] opcode;
    logic       pcWr, pcWrBeq, pcWrBne, iorD, memRd, memWr, irWr, mem2Reg, regDst, regWr;
    logic       ALUSrcA, instrDone, illegal;
    logic [1:0] ALUSrcB, ALUOp, pcSrc;
    logic [3:0] state;
    logic [18:0] dut_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [5:0] op_lat = '0;
    logic trap_seen = 1'b0;
    vec_t vecs[$];

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .memReady(memReady), .halt(halt),
        .pcWr(pcWr), .pcWrBeq(pcWrBeq), .pcWrBne(pcWrBne), .iorD(iorD), .memRd(memRd),
        .memWr(memWr), .irWr(irWr), .mem2Reg(mem2Reg), .regDst(regDst), .regWr(regWr),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .pcSrc(pcSrc),
        .instrDone(instrDone), .illegal(illegal), .state(state)
    );

    assign dut_out = {pcWr, pcWrBeq, pcWrBne, iorD, memRd, memWr, irWr, mem2Reg, regDst,
                      regWr, ALUSrcA, ALUSrcB, ALUOp, pcSrc, instrDone, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Expected control outputs for a state, written from the state/output table.
    function automatic logic [18:0] exp_out(input st_e s, input logic [5:0] op,
                                            input logic rdy, input logic ill);
        logic pw, pbeq, pbne, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, idone;
        logic [1:0] asb, aop, psrc;
        {pw, pbeq, pbne, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, idone} = '0;
        {asb, aop, psrc} = '0;
        case (s)
            FETCH:    begin mrd = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            DECODE:   asb = 2'b11;
            MEMADDR:  begin asa = 1; asb = 2'b10; end
            MEMREAD:  begin mrd = 1; iod = 1; end
            MEMWB:    begin rwr = 1; m2r = 1; idone = 1; end
            MEMWRITE: begin mwr = 1; iod = 1; idone = rdy; end
            EXEC:     begin asa = 1; aop = 2'b10; end
            RWB:      begin rwr = 1; rdst = 1; idone = 1; end
            IEXEC:    begin asa = 1; asb = 2'b10; aop = (op == 6'b001100) ? 2'b11 : 2'b00; end
            IWB:      begin rwr = 1; idone = 1; end
            BRANCH:   begin asa = 1; aop = 2'b01; psrc = 2'b01; idone = 1;
                            pbeq = (op == 6'b000100); pbne = (op == 6'b000101); end
            JUMP:     begin pw = 1; psrc = 2'b10; idone = 1; end
            default:  ;
        endcase
        return {pw, pbeq, pbne, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc, idone, ill};
    endfunction

    function automatic void add(input string n, input logic h, input logic m,
                                input logic [5:0] op, input st_e s);
        vec_t v;
        v.name = n; v.halt = h; v.mem_ready = m; v.opcode = op; v.exp_state = s;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        halt     = v.halt;
        memReady = v.mem_ready;
        opcode   = v.opcode;
        #1;
        if (v.exp_state == DECODE) op_lat = v.opcode;
        if (v.exp_state == TRAP) trap_seen = 1'b1;
        check($sformatf("%s[%0d]/state", v.name, idx), 32'(state), 32'(v.exp_state));
        check($sformatf("%s[%0d]/ctrl", v.name, idx), 32'(dut_out),
              32'(exp_out(v.exp_state, op_lat, v.mem_ready, trap_seen)));
    endtask

    task automatic step(input string n, input logic h, input logic m,
                        input logic [5:0] op, input st_e s);
        vec_t v;
        v.name = n; v.halt = h; v.mem_ready = m; v.opcode = op; v.exp_state = s;
        apply(v, 0);
    endtask

    initial begin
        rstn = 1'b0; halt = 1'b1; memReady = 1'b1; opcode = 6'b000000;

        // R-type
        add("idle_halt", 1, 1, 6'b000000, IDLE);
        add("idle_go",   0, 1, 6'b000000, IDLE);
        add("r_fetch",   0, 1, 6'b000000, FETCH);
        add("r_decode",  0, 1, 6'b000000, DECODE);
        add("r_exec",    0, 1, 6'b000000, EXEC);
        add("r_wb",      0, 1, 6'b000000, RWB);
        // lw with 2 fetch stalls and 3 read stalls; IR changes after DECODE
        add("lw_fetch_wait", 0, 0, 6'b100011, FETCH);
        add("lw_fetch_wait", 0, 0, 6'b100011, FETCH);
        add("lw_fetch",      0, 1, 6'b100011, FETCH);
        add("lw_decode",     0, 1, 6'b100011, DECODE);
        add("lw_addr",       0, 1, 6'b101011, MEMADDR);
        add("lw_read_wait",  0, 0, 6'b101011, MEMREAD);
        add("lw_read_wait",  0, 0, 6'b101011, MEMREAD);
        add("lw_read_wait",  0, 0, 6'b101011, MEMREAD);
        add("lw_read",       0, 1, 6'b101011, MEMREAD);
        add("lw_wb",         0, 1, 6'b101011, MEMWB);
        // sw, halt high outside IDLE must be ignored
        add("sw_fetch",  1, 1, 6'b101011, FETCH);
        add("sw_decode", 1, 1, 6'b101011, DECODE);
        add("sw_addr",   1, 1, 6'b101011, MEMADDR);
        add("sw_write",  1, 1, 6'b101011, MEMWRITE);
        // sw with one write stall
        add("sw2_fetch",      0, 1, 6'b101011, FETCH);
        add("sw2_decode",     0, 1, 6'b101011, DECODE);
        add("sw2_addr",       0, 1, 6'b101011, MEMADDR);
        add("sw2_write_wait", 0, 0, 6'b101011, MEMWRITE);
        add("sw2_write",      0, 1, 6'b101011, MEMWRITE);
        // beq (IR switches to bne in BRANCH), then bne
        add("beq_fetch",  0, 1, 6'b000100, FETCH);
        add("beq_decode", 0, 1, 6'b000100, DECODE);
        add("beq_branch", 0, 1, 6'b000101, BRANCH);
        add("bne_fetch",  0, 1, 6'b000101, FETCH);
        add("bne_decode", 0, 1, 6'b000101, DECODE);
        add("bne_branch", 0, 1, 6'b000101, BRANCH);
        // j
        add("j_fetch",  0, 1, 6'b000010, FETCH);
        add("j_decode", 0, 1, 6'b000010, DECODE);
        add("j_jump",   0, 1, 6'b000010, JUMP);
        // addi, andi (IR garbage after DECODE)
        add("addi_fetch",  0, 1, 6'b001000, FETCH);
        add("addi_decode", 0, 1, 6'b001000, DECODE);
        add("addi_exec",   0, 1, 6'b001000, IEXEC);
        add("addi_wb",     0, 1, 6'b001000, IWB);
        add("andi_fetch",  0, 1, 6'b001100, FETCH);
        add("andi_decode", 0, 1, 6'b001100, DECODE);
        add("andi_exec",   0, 1, 6'b111111, IEXEC);
        add("andi_wb",     0, 1, 6'b111111, IWB);
        // illegal opcode -> sticky trap
        add("ill_fetch",  0, 1, 6'b111111, FETCH);
        add("ill_decode", 0, 1, 6'b111111, DECODE);
        add("ill_trap",   0, 1, 6'b111111, TRAP);
        add("ill_trap",   1, 0, 6'b000000, TRAP);
        add("ill_trap",   0, 1, 6'b100011, TRAP);

        #12;
        check("reset/state", 32'(state), 32'(IDLE));
        check("reset/ctrl", 32'(dut_out), 32'(0));

        @(negedge clk);
        rstn = 1'b1;
        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset from TRAP clears illegal immediately
        #1;
        rstn = 1'b0;
        #1;
        trap_seen = 1'b0;
        check("trap_rst/state", 32'(state), 32'(IDLE));
        check("trap_rst/ctrl", 32'(dut_out), 32'(0));

        @(negedge clk);
        halt = 1'b0;
        rstn = 1'b1;
        step("rst_fetch",  0, 1, 6'b100011, FETCH);
        step("rst_decode", 0, 1, 6'b100011, DECODE);
        step("rst_addr",   0, 1, 6'b100011, MEMADDR);
        step("rst_read",   0, 1, 6'b100011, MEMREAD);

        // Async reset mid-cycle in MEMREAD, before the edge that would enter MEMWB
        #2;
        rstn = 1'b0;
        #1;
        check("memread_rst/state", 32'(state), 32'(IDLE));
        check("memread_rst/ctrl", 32'(dut_out), 32'(0));
        @(posedge clk);
        #1;
        check("memread_rst_hold/state", 32'(state), 32'(IDLE));
        check("memread_rst_hold/ctrl", 32'(dut_out), 32'(0));

        @(negedge clk);
        halt = 1'b1;
        rstn = 1'b1;
        step("post_idle_halt", 1, 1, 6'b000010, IDLE);
        step("post_idle_go",   0, 1, 6'b000010, IDLE);
        step("post_fetch",     0, 1, 6'b000010, FETCH);
        step("post_decode",    0, 1, 6'b000010, DECODE);
        step("post_jump",      0, 1, 6'b000010, JUMP);
        step("post_fetch2",    0, 0, 6'b000010, FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
